// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard, multicycle-op and exception redirect controller
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   stall_req[NSTAGE]   : per-stage external stall requests
//   ld_pending, ld_rt   : load in EX and its destination register
//   id_rs, id_rt        : decode-stage source registers
//   mc_op, mc_ready     : multicycle op present in EX, unit result valid
//   exc_type, cp0_epc   : memory-stage exception code (0 = none) and EPC
//   stall, flush        : per-stage hold and bubble controls
//   mc_start, mc_abort  : single-cycle pulses to the multicycle unit
//   redirect_valid/_pc  : PC redirect on exception
//   stall_cnt           : saturating count of cycles with stall[0]=1
module pipe_ctrl #(
  parameter int          NSTAGE    = 5,
  parameter int          ID_IDX    = 1,
  parameter int          EX_IDX    = 2,
  parameter int          MEM_IDX   = 3,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE = 32'h0000000E,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic              ld_pending,
  input  logic [4:0]        ld_rt,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              mc_op,
  input  logic              mc_ready,
  input  logic [31:0]       exc_type,
  input  logic [31:0]       cp0_epc,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic              mc_start,
  output logic              mc_abort,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t             r_state, w_next;
  logic               r_pend_valid;
  logic [31:0]        r_pend_type, r_pend_epc;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic               w_load_use, w_mc_busy;
  logic [NSTAGE-1:0]  w_req, w_stall_raw, w_flush_raw;
  logic               w_exc_live, w_blocked, w_redirect;
  logic [31:0]        w_sel_type, w_sel_epc;

  // Register 0 is hardwired zero, so a load to it never creates a hazard.
  assign w_load_use = ld_pending & (ld_rt != 5'd0) & ((ld_rt == id_rs) | (ld_rt == id_rt));
  assign w_mc_busy  = ((r_state == S_IDLE) & mc_op) | (r_state == S_BUSY);
  assign w_req      = stall_req
                    | (NSTAGE'(w_load_use) << ID_IDX)
                    | (NSTAGE'(w_mc_busy)  << EX_IDX);

  // A stalled stage holds every older (lower-index) stage; the bubble goes
  // into the first stage behind the oldest stalled one.
  always_comb begin
    logic acc;
    acc            = 1'b0;
    w_stall_raw    = '0;
    w_flush_raw    = '0;
    for (int i = NSTAGE - 1; i >= 0; i--) begin
      acc            = acc | w_req[i];
      w_stall_raw[i] = acc;
    end
    for (int i = 0; i < NSTAGE - 1; i++) begin
      w_flush_raw[i+1] = w_stall_raw[i] & ~w_stall_raw[i+1];
    end
  end

  // A live exception is ignored while one is already pending; the pending one
  // is older and wins when the memory side stops stalling.
  assign w_exc_live = (exc_type != 32'd0);
  assign w_blocked  = |stall_req[NSTAGE-1:MEM_IDX];
  assign w_redirect = (r_pend_valid | w_exc_live) & ~w_blocked;
  assign w_sel_type = r_pend_valid ? r_pend_type : exc_type;
  assign w_sel_epc  = r_pend_valid ? r_pend_epc  : cp0_epc;

  assign redirect_valid = w_redirect;
  assign redirect_pc    = !w_redirect               ? 32'd0 :
                          (w_sel_type == ERET_CODE) ? w_sel_epc : EXC_VEC;
  assign stall          = w_redirect ? '0 : w_stall_raw;
  assign flush          = w_redirect ? '1 : w_flush_raw;
  assign stall_cnt      = r_stall_cnt;

  always_comb begin
    w_next   = r_state;
    mc_start = 1'b0;
    mc_abort = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mc_op && !w_redirect) begin
          mc_start = 1'b1;
          w_next   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_redirect) begin
          mc_abort = 1'b1;
          w_next   = S_IDLE;
        end else if (mc_ready) begin
          w_next   = S_DONE;
        end
      end
      // DONE lets EX advance for one cycle so the same op is not restarted.
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pend_valid <= 1'b0;
      r_pend_type  <= 32'd0;
      r_pend_epc   <= 32'd0;
      r_stall_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_redirect) begin
        r_pend_valid <= 1'b0;
        r_pend_type  <= 32'd0;
        r_pend_epc   <= 32'd0;
      end else if (w_exc_live && w_blocked && !r_pend_valid) begin
        r_pend_valid <= 1'b1;
        r_pend_type  <= exc_type;
        r_pend_epc   <= cp0_epc;
      end
      if (stall[0] && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard testbench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  stall_req = '0;
  logic        ld_pending = 1'b0;
  logic [4:0]  ld_rt = '0, id_rs = '0, id_rt = '0;
  logic        mc_op = 1'b0, mc_ready = 1'b0;
  logic [31:0] exc_type = '0, cp0_epc = '0;
  logic [4:0]  stall, flush;
  logic        mc_start, mc_abort, redirect_valid;
  logic [31:0] redirect_pc;
  logic [15:0] stall_cnt;

  localparam logic [31:0] E = 32'h0000000E;
  localparam logic [31:0] V = 32'hBFC00380;
  localparam logic [31:0] P = 32'h80001000;

  typedef struct {
    logic [4:0]  st, fl;
    logic        ms, ma, rv;
    logic [31:0] pc;
    logic [15:0] cnt;
    string       nm;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_cnt = '0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .ld_pending(ld_pending),
    .ld_rt(ld_rt), .id_rs(id_rs), .id_rt(id_rt), .mc_op(mc_op), .mc_ready(mc_ready),
    .exc_type(exc_type), .cp0_epc(cp0_epc), .stall(stall), .flush(flush),
    .mc_start(mc_start), .mc_abort(mc_abort), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the oldest expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, "/stall"},    32'(stall),          32'(e.st));
        chk({e.nm, "/flush"},    32'(flush),          32'(e.fl));
        chk({e.nm, "/mc_start"}, 32'(mc_start),       32'(e.ms));
        chk({e.nm, "/mc_abort"}, 32'(mc_abort),       32'(e.ma));
        chk({e.nm, "/redir_v"},  32'(redirect_valid), 32'(e.rv));
        chk({e.nm, "/redir_pc"}, redirect_pc,         e.pc);
        chk({e.nm, "/cnt"},      32'(stall_cnt),      32'(e.cnt));
      end
    end
  end

  // One cycle of stimulus plus its hand-computed response.
  task automatic s(input logic r, input logic [4:0] sr, input logic lp,
                   input logic [4:0] lrt, input logic [4:0] rs, input logic [4:0] rt,
                   input logic mo, input logic mr, input logic [31:0] et, input logic [31:0] epc,
                   input logic [4:0] xs, input logic [4:0] xf, input logic xms, input logic xma,
                   input logic xrv, input logic [31:0] xpc, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall_req = sr; ld_pending = lp; ld_rt = lrt; id_rs = rs; id_rt = rt;
    mc_op = mo; mc_ready = mr; exc_type = et; cp0_epc = epc;
    if (r) exp_cnt = '0;
    e.st = xs; e.fl = xf; e.ms = xms; e.ma = xma; e.rv = xrv; e.pc = xpc;
    e.cnt = exp_cnt; e.nm = nm;
    q.push_back(e);
    if (!r && xs[0] && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
  endtask

  initial begin
    // reset and load-use
    s(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "reset");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "idle");
    s(0, 5'b00000, 1, 5, 5, 0, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0, 0, 0, "lu_rs");
    s(0, 5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "lu_r0");
    s(0, 5'b00000, 1, 7, 3, 7, 0, 0, 0, 0, 5'b00011, 5'b00100, 0, 0, 0, 0, "lu_rt");
    s(0, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 0, 0, 0, "sr3");
    s(0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 0, 0, 0, "sr0");
    // divide: IDLE + 4 BUSY stall, released in DONE
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0, 0, "div_idle");
    for (int i = 0; i < 3; i++)
      s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0, 0, "div_busy");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 0, 0, "div_rdy");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "div_done");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "div_after");
    // ERET
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, E, P, 5'b00000, 5'b11111, 0, 0, 1, P, "eret");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, P, 5'b00000, 5'b00000, 0, 0, 0, 0, "eret_after");
    // blocked exception; pending wins over a later live ERET
    s(0, 5'b01000, 0, 0, 0, 0, 0, 0, 4, P, 5'b01111, 5'b10000, 0, 0, 0, 0, "blk1");
    s(0, 5'b01000, 0, 0, 0, 0, 0, 0, E, 32'h1234, 5'b01111, 5'b10000, 0, 0, 0, 0, "blk2");
    s(0, 5'b01000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 0, 0, 0, 0, "blk3");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, E, P, 5'b00000, 5'b11111, 0, 0, 1, V, "blk_rel");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "blk_after");
    // redirect during BUSY, late mc_ready ignored, FSM restarts from IDLE
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0, 0, "ab_start");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0, 0, "ab_busy");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 8, 0, 5'b00000, 5'b11111, 0, 1, 1, V, "ab_redir");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "ab_late");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0, 0, "ab_restart");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 0, 0, "ab_rdy");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "ab_done");
    // redirect in IDLE suppresses mc_start
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 8, 0, 5'b00000, 5'b11111, 0, 0, 1, V, "sup");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0, 0, "sup_after");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00111, 5'b01000, 0, 0, 0, 0, "sup_rdy");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "sup_done");
    // reset mid-BUSY gives no abort
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 1, 0, 0, 0, "rb_start");
    s(0, 5'b00000, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00111, 5'b01000, 0, 0, 0, 0, "rb_busy");
    s(1, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "rb_rst");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "rb_rel");
    // stall counter saturation, then asynchronous clear
    for (int i = 0; i < 65539; i++)
      s(0, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 0, 0, 0, "sat");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "sat_hold");
    s(1, 5'b00001, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 0, 0, 0, "sat_rst");
    s(0, 5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0, 0, 0, 0, "final");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    chk("sat_value_model", 32'(exp_cnt), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL provide parameter NSTAGE, default 5, number of pipeline stages (index 0 = fetch).
REQ-002 SHALL provide parameters ID_IDX=1, EX_IDX=2, MEM_IDX=3, the stage indices of decode, execute and memory.
REQ-003 SHALL provide parameter EXC_VEC, default 32'hBFC00380, the general exception entry address.
REQ-004 SHALL provide parameter ERET_CODE, default 32'h0000000E, the exception code that returns to EPC.
REQ-005 SHALL provide parameter CNT_W, default 16, the stall-counter width.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port stall_req, input, NSTAGE, per-stage external stall request (e.g. I-fetch miss, D-mem busy).
REQ-009 SHALL have ports ld_pending (input, 1), ld_rt, id_rs and id_rt (input, 5 each): a load in EX and its destination, plus the decode sources.
REQ-010 SHALL have ports mc_op (input, 1, multicycle op in EX) and mc_ready (input, 1, unit result valid).
REQ-011 SHALL have ports exc_type and cp0_epc, input, 32 each: memory-stage exception code (0 = none) and EPC.
REQ-012 SHALL have ports stall and flush, output, NSTAGE each, per-stage hold and bubble controls.
REQ-013 SHALL have ports mc_start and mc_abort, output, 1 each, single-cycle pulses to the multicycle unit.
REQ-014 SHALL have ports redirect_valid (output, 1) and redirect_pc (output, 32), the PC redirect on exception.
REQ-015 SHALL have port stall_cnt, output, CNT_W, saturating count of cycles with stall[0]=1.

Function
REQ-016 SHALL form the effective request req_eff = stall_req, OR-ing the load-use term into bit ID_IDX and the mc_busy term into bit EX_IDX.
REQ-017 SHALL define the load-use term as ld_pending & (ld_rt!=0) & (ld_rt==id_rs | ld_rt==id_rt).
REQ-018 SHALL assert stall[i] = OR of req_eff[j] for j>=i: a stalling stage holds all older stages.
REQ-019 SHALL assert flush[i+1] = stall[i] & ~stall[i+1] for i<NSTAGE-1, inserting one bubble behind the oldest stalled stage; flush[0]=0 except on redirect.
REQ-020 SHALL implement a multicycle FSM with states IDLE, BUSY and DONE.
REQ-021 In IDLE with mc_op=1 and no redirect, the FSM SHALL pulse mc_start for one cycle and go to BUSY.
REQ-022 In BUSY the FSM SHALL wait for mc_ready=1, then go to DONE.
REQ-023 The FSM SHALL leave DONE for IDLE after exactly one cycle.
REQ-024 SHALL define mc_busy = (IDLE & mc_op) | BUSY; DONE releases EX, so the op is not restarted.
REQ-025 SHALL ignore mc_ready while in IDLE or DONE.
REQ-026 An exception is blocked when exc_type!=0 and any stall_req[k]=1 for k>=MEM_IDX.
REQ-027 A blocked exception SHALL be latched (type, epc) into a pending register; exc_type is ignored while an exception is pending.
REQ-028 SHALL assert redirect_valid for exactly one cycle, the first cycle an exception (pending or live, pending has priority) is unblocked.
REQ-029 redirect_pc SHALL equal the epc if the exception type equals ERET_CODE, otherwise EXC_VEC; it is 0 when redirect_valid=0.
REQ-030 In the redirect cycle flush SHALL be all ones and stall all zeros, overriding REQ-018/019; the pending register is cleared.
REQ-031 A redirect while the FSM is in BUSY SHALL pulse mc_abort and return the FSM to IDLE the next cycle.
REQ-032 A redirect while the FSM is in IDLE with mc_op=1 SHALL suppress mc_start.
REQ-033 stall_cnt SHALL increment by 1 per cycle with stall[0]=1 and hold at all ones.

Reset
REQ-034 On rst=1, asynchronously: FSM to IDLE, pending cleared, stall_cnt=0; all registered outputs 0; combinational outputs follow from the cleared state.
REQ-035 Reset asserted mid-BUSY SHALL NOT produce mc_abort; the multicycle unit is reset separately.

Verification
REQ-036 Load-use: ld_pending=1, ld_rt=5, id_rs=5 -> stall=5'b00011, flush=5'b00100; ld_rt=0 -> no stall.
REQ-037 Divide: mc_op held, mc_ready after 4 cycles -> mc_start one pulse, stall[2:0]=1 for 5 cycles (IDLE plus 4 BUSY), released in DONE, no second mc_start.
REQ-038 ERET: exc_type=0xE, cp0_epc=0x80001000, no stalls -> redirect_valid for 1 cycle, redirect_pc=0x80001000, flush=5'b11111.
REQ-039 Blocked exception: exc_type=0x4 with stall_req[3]=1 for 3 cycles, exc_type cleared after the first -> redirect 1 cycle after release, redirect_pc=0xBFC00380.
REQ-040 Redirect during BUSY -> mc_abort pulse; FSM in IDLE next cycle; a late mc_ready is ignored.
REQ-041 stall_req[0] held 2^CNT_W+3 cycles -> stall_cnt saturates at all ones; rst clears it to 0 asynchronously.
